instruction_fetch_buffer: RTL and testbench

- Front end of the six-stage core. Replaces the async instruction ROM path with a synchronous instruction memory that has 1-cycle read latency.
- Generates sequential fetch addresses, tracks the in-flight read, and queues returned instructions with their PC in a small prefetch FIFO.
- Presents the FIFO head to the IF/ID pipeline register through a valid/ready handshake.
- Accepts a single redirect (predicted-taken or mispredict target, already prioritised upstream), which flushes queued and in-flight fetches.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 45 ++++
 rtl/instruction_fetch_buffer.sv | 70 +++++++
 tb/tb_instruction_fetch_buffer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end
package fetch_pkg;
    localparam int FETCH_XLEN = 32;
    localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instruction;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue of {pc, instruction} entries with a priority flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int W     = 2 * FETCH_XLEN,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    assign count = r_count;
    assign head  = r_mem[r_head];
    // storage is cleared on reset so the head reads as zero until the first push
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_mem[r_tail] <= push_data;
                r_tail        <= r_tail + 1'b1;
            end
            if (pop) r_head <= r_head + 1'b1;
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/instruction_fetch_buffer.sv
// instruction_fetch_buffer: sequential fetch over a 1-cycle memory into a prefetch FIFO
module instruction_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int               XLEN     = FETCH_XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_read_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [31:0]     fetch_instruction,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] fetch_pc_plus_four
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [XLEN-1:0]    r_next_pc;
    logic [XLEN-1:0]    r_pending_pc;
    logic               r_inflight;
    logic [CW-1:0]      w_count;
    logic [CW-1:0]      w_occupancy;
    logic [XLEN+31:0]   w_head;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    // a slot is reserved for the in-flight read, so a response can always be queued
    assign w_occupancy        = w_count + CW'(r_inflight);
    assign w_issue            = reset && !redirect_valid && (w_occupancy < CW'(DEPTH));
    assign w_push             = r_inflight && !redirect_valid;
    assign w_pop              = fetch_valid && fetch_ready && !redirect_valid;
    assign imem_read_en       = w_issue;
    assign imem_addr          = r_next_pc;
    assign fetch_valid        = w_count != '0;
    assign fetch_pc           = w_head[XLEN+31:32];
    assign fetch_instruction  = w_head[31:0];
    assign fetch_pc_plus_four = fetch_pc + XLEN'(4);
    // fetch address sequencing and tracking of the single outstanding read
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_next_pc    <= RESET_PC;
            r_pending_pc <= '0;
            r_inflight   <= 1'b0;
        end else if (redirect_valid) begin
            r_next_pc  <= {redirect_pc[XLEN-1:2], 2'b00};
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pending_pc <= r_next_pc;
                r_next_pc    <= r_next_pc + XLEN'(4);
            end
        end
    end
    fetch_fifo #(.W(XLEN + 32), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({r_pending_pc, imem_data}),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .count     (w_count),
        .head      (w_head)
    );
endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// tb_instruction_fetch_buffer: directed and random checks of the fetch buffer against a PC-stream model
module tb_instruction_fetch_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_read_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instruction;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_plus_four;
    int          n_assert = 0;
    int          n_fail = 0;
    int          issued = 0;
    int          delivered = 0;
    logic [31:0] exp_pc = 32'h0;

    instruction_fetch_buffer dut (
        .clk                (clk),
        .reset              (reset),
        .imem_read_en       (imem_read_en),
        .imem_addr          (imem_addr),
        .imem_data          (imem_data),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .fetch_valid        (fetch_valid),
        .fetch_ready        (fetch_ready),
        .fetch_instruction  (fetch_instruction),
        .fetch_pc           (fetch_pc),
        .fetch_pc_plus_four (fetch_pc_plus_four)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    // synchronous memory: word for the requested address appears one cycle later
    always @(posedge clk) if (imem_read_en) imem_data <= enc(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // the model: accepted instructions form a gapless +4 stream from the last reset/redirect target
    task automatic cyc();
        @(negedge clk);
        if (!reset) exp_pc = 32'h0;
        else if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
        else begin
            if (imem_read_en) issued++;
            if (fetch_valid && fetch_ready) begin
                check("pop_pc", fetch_pc, exp_pc);
                check("pop_insn", fetch_instruction, enc(exp_pc));
                check("pop_pc4", fetch_pc_plus_four, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; fetch_ready = 1'b0;
        cyc(); cyc();
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_read_en", 32'(imem_read_en), 32'd0);
        check("rst_insn", fetch_instruction, 32'd0);
        check("rst_pc", fetch_pc, 32'd0);
        check("rst_pc4", fetch_pc_plus_four, 32'd4);
        reset = 1'b1; fetch_ready = 1'b1;
        cyc();
        check("warm_valid_c1", 32'(fetch_valid), 32'd0);
        cyc();
        check("warm_valid_c2", 32'(fetch_valid), 32'd1);
        check("warm_first_pc", fetch_pc, 32'h0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("stream_no_gap", 32'(fetch_valid), 32'd1);
        end
        check("stream_count", 32'(delivered), 32'd12);

        reset = 1'b0; cyc();
        reset = 1'b1; fetch_ready = 1'b0; issued = 0;
        for (int i = 0; i < 10; i++) cyc();
        check("full_issued", 32'(issued), 32'd4);
        check("full_read_en", 32'(imem_read_en), 32'd0);
        check("full_head_pc", fetch_pc, 32'h0);
        fetch_ready = 1'b1; cyc();
        check("resume_read_en", 32'(imem_read_en), 32'd1);
        fetch_ready = 1'b0; cyc();
        check("refull_read_en", 32'(imem_read_en), 32'd0);
        check("refull_head_pc", fetch_pc, 32'h4);

        redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        check("redir_no_issue", 32'(imem_read_en), 32'd0);
        cyc();
        redirect_valid = 1'b0; fetch_ready = 1'b1; #1;
        check("redir_n_valid", 32'(fetch_valid), 32'd0);
        check("redir_n_read_en", 32'(imem_read_en), 32'd1);
        check("redir_n_addr", imem_addr, 32'h100);
        cyc();
        check("redir_n1_valid", 32'(fetch_valid), 32'd0);
        cyc();
        check("redir_n2_valid", 32'(fetch_valid), 32'd1);
        check("redir_n2_pc", fetch_pc, 32'h100);
        for (int i = 0; i < 8; i++) cyc();

        redirect_valid = 1'b1; redirect_pc = 32'h203;
        cyc();
        redirect_valid = 1'b0; #1;
        check("unalign_valid", 32'(fetch_valid), 32'd0);
        check("unalign_addr", imem_addr, 32'h200);
        cyc(); cyc();
        check("unalign_pc", fetch_pc, 32'h200);
        check("unalign_insn", fetch_instruction, enc(32'h200));
        for (int i = 0; i < 6; i++) cyc();

        redirect_valid = 1'b1; redirect_pc = 32'h40; cyc();
        redirect_pc = 32'h80; cyc();
        redirect_valid = 1'b0; #1;
        check("b2b_addr", imem_addr, 32'h80);
        cyc(); cyc();
        check("b2b_valid", 32'(fetch_valid), 32'd1);
        check("b2b_pc", fetch_pc, 32'h80);
        for (int i = 0; i < 8; i++) cyc();

        fetch_ready = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        fetch_ready = 1'b1; cyc();
        fetch_ready = 1'b0; cyc();
        check("pre_rst_full", 32'(imem_read_en), 32'd0);
        reset = 1'b0; cyc();
        check("mid_rst_valid", 32'(fetch_valid), 32'd0);
        check("mid_rst_read_en", 32'(imem_read_en), 32'd0);
        reset = 1'b1; fetch_ready = 1'b1;
        cyc(); cyc();
        check("restart_valid", 32'(fetch_valid), 32'd1);
        check("restart_pc", fetch_pc, 32'h0);
        check("restart_insn", fetch_instruction, enc(32'h0));
        for (int i = 0; i < 6; i++) cyc();

        delivered = 0;
        for (int i = 0; i < 400; i++) begin
            fetch_ready    = $urandom_range(0, 3) != 0;
            redirect_valid = $urandom_range(0, 19) == 0;
            redirect_pc    = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
            reset          = $urandom_range(0, 99) != 0;
            cyc();
        end
        check("random_progress", 32'(delivered >= 100), 32'd1);
        reset = 1'b1; redirect_valid = 1'b0; fetch_ready = 1'b1;
        cyc(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
